// File: rtl/scan_pkg.sv
// Shared sizing helpers and legality rules for the SCAN beta store.
// Layer l holds 2^l entries; writes deliver two halves, reads return one P-wide block.
package scan_pkg;

  localparam int unsigned Q_DEF = 6;
  localparam int unsigned P_DEF = 128;
  localparam int unsigned N_DEF = 1024;

  function automatic int unsigned lmax_of(input int unsigned n);
    return $clog2(n) - 2;
  endfunction

  function automatic int unsigned lw_of(input int unsigned lmax);
    return $clog2(lmax + 1);
  endfunction

  function automatic int unsigned cw_of(input int unsigned lmax, input int unsigned p);
    int unsigned w;
    w = $clog2((32'd1 << lmax) / p);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int unsigned xw_of(input int unsigned nctx);
    int unsigned w;
    w = $clog2(nctx);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int unsigned layer_size(input int unsigned l);
    return 32'd1 << l;
  endfunction

  // A write carries H=S/2 entries per half, so its count range is set by H
  function automatic logic wr_cnt_ok(input int unsigned l, input int unsigned c,
                                     input int unsigned p);
    int unsigned h;
    h = layer_size(l) / 2;
    return (h >= p) ? (c < h / p) : (c == 0);
  endfunction

  function automatic logic rd_cnt_ok(input int unsigned l, input int unsigned c,
                                     input int unsigned p);
    int unsigned s;
    s = layer_size(l);
    return (s >= p) ? (c < s / p) : (c == 0);
  endfunction

endpackage

// File: rtl/scan_beta_store_if.sv
// Write/read/clear bus between the PE array, the beta store and the combine stage.
interface scan_beta_store_if #(
  parameter int unsigned Q  = 6,
  parameter int unsigned P  = 128,
  parameter int unsigned LW = 4,
  parameter int unsigned CW = 1,
  parameter int unsigned XW = 1
);
  logic                 w_en;
  logic [LW-1:0]        w_layer;
  logic [CW-1:0]        w_cnt;
  logic [XW-1:0]        w_ctx;
  logic [2*P*Q-1:0]     w_data;
  logic                 r_en;
  logic [LW-1:0]        r_layer;
  logic [CW-1:0]        r_cnt;
  logic [XW-1:0]        r_ctx;
  logic                 clr;
  logic [XW-1:0]        clr_ctx;
  logic [P*Q-1:0]       r_data;
  logic                 r_valid;
  logic                 err;

  modport master (
    output w_en, w_layer, w_cnt, w_ctx, w_data,
    output r_en, r_layer, r_cnt, r_ctx, clr, clr_ctx,
    input  r_data, r_valid, err
  );

  modport slave (
    input  w_en, w_layer, w_cnt, w_ctx, w_data,
    input  r_en, r_layer, r_cnt, r_ctx, clr, clr_ctx,
    output r_data, r_valid, err
  );
endinterface

// File: rtl/scan_beta_layer.sv
// One beta bank (layer L, one context): half-split write mapping, P-wide read with
// zero-extension for small layers, whole-bank clear, optional write-first forwarding.
module scan_beta_layer #(
  parameter int unsigned Q      = 6,
  parameter int unsigned P      = 128,
  parameter int unsigned L      = 1,
  parameter int unsigned CW     = 1,
  parameter bit          BYPASS = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we,
  input  logic [CW-1:0]    i_wcnt,
  input  logic [2*P*Q-1:0] i_wdata,
  input  logic             i_clr,
  input  logic [CW-1:0]    i_rcnt,
  output logic [P*Q-1:0]   o_rdata
);
  localparam int unsigned S  = 32'd1 << L;
  localparam int unsigned H  = S / 2;
  localparam int unsigned PQ = P * Q;
  localparam int unsigned AW = L;

  logic [Q-1:0] r_mem [S];
  logic         w_hit [S];
  logic [Q-1:0] w_val [S];

  // Inverse mapping: for each stored entry, does this write touch it and with what
  always_comb begin
    int unsigned off;
    int unsigned k;
    int unsigned base;
    logic        upper;
    off   = 0;
    k     = 0;
    base  = 0;
    upper = 1'b0;
    for (int unsigned i = 0; i < S; i++) begin
      upper = (i >= H);
      off   = upper ? i - H : i;
      if (H >= P) begin
        k        = off % P;
        w_hit[i] = ((off / P) == 32'(i_wcnt));
      end else begin
        k        = off;
        w_hit[i] = 1'b1;
      end
      base     = (upper ? PQ : 0) + k * Q;
      w_val[i] = i_wdata[base +: Q];
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < S; i++) begin
      if (rst || i_clr)
        r_mem[i] <= '0;
      else if (i_we && w_hit[i])
        r_mem[i] <= w_val[i];
    end
  end

  always_comb begin
    int unsigned  idx;
    logic [Q-1:0] ent;
    idx     = 0;
    ent     = '0;
    o_rdata = '0;
    for (int unsigned k = 0; k < P; k++) begin
      idx = (S >= P) ? 32'(i_rcnt) * P + k : k;
      if (idx < S) begin
        ent = (BYPASS && i_we && w_hit[AW'(idx)]) ? w_val[AW'(idx)] : r_mem[AW'(idx)];
        o_rdata[k*Q +: Q] = ent;
      end
    end
  end
endmodule

// File: rtl/scan_beta_store.sv
// Beta store top: LMAX x NCTX layer banks, access legality checks, registered read path.
module scan_beta_store
  import scan_pkg::*;
#(
  parameter int unsigned Q      = Q_DEF,
  parameter int unsigned P      = P_DEF,
  parameter int unsigned N      = N_DEF,
  parameter int unsigned LMAX   = lmax_of(N),
  parameter int unsigned NCTX   = 2,
  parameter bit          BYPASS = 1'b0
) (
  input logic         clk,
  input logic         rst,
  scan_beta_store_if.slave bus
);
  localparam int unsigned LW = lw_of(LMAX);
  localparam int unsigned CW = cw_of(LMAX, P);
  localparam int unsigned XW = xw_of(NCTX);
  localparam int unsigned PQ = P * Q;

  logic           w_wlegal;
  logic           w_rlegal;
  logic [PQ-1:0]  w_rsel;
  logic [PQ-1:0]  w_rd [LMAX][NCTX];
  logic [PQ-1:0]  r_rdata;
  logic           r_rvalid;
  logic           r_err;

  assign w_wlegal = (bus.w_layer != '0) && (32'(bus.w_layer) <= LMAX) &&
                    (32'(bus.w_ctx) < NCTX) &&
                    wr_cnt_ok(32'(bus.w_layer), 32'(bus.w_cnt), P);
  assign w_rlegal = (bus.r_layer != '0) && (32'(bus.r_layer) <= LMAX) &&
                    (32'(bus.r_ctx) < NCTX) &&
                    rd_cnt_ok(32'(bus.r_layer), 32'(bus.r_cnt), P);

  for (genvar l = 1; l <= LMAX; l++) begin : g_layer
    for (genvar x = 0; x < NCTX; x++) begin : g_ctx
      logic w_lclr;
      logic w_lwe;
      // Clear of this context wins over a same-cycle write, and also suppresses forwarding
      assign w_lclr = bus.clr && (bus.clr_ctx == XW'(x));
      assign w_lwe  = bus.w_en && w_wlegal && !w_lclr &&
                      (bus.w_layer == LW'(l)) && (bus.w_ctx == XW'(x));

      scan_beta_layer #(
        .Q      (Q),
        .P      (P),
        .L      (l),
        .CW     (CW),
        .BYPASS (BYPASS)
      ) u_layer (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_lwe),
        .i_wcnt  (bus.w_cnt),
        .i_wdata (bus.w_data),
        .i_clr   (w_lclr),
        .i_rcnt  (bus.r_cnt),
        .o_rdata (w_rd[l-1][x])
      );
    end
  end

  always_comb begin
    w_rsel = '0;
    for (int unsigned l = 1; l <= LMAX; l++)
      for (int unsigned x = 0; x < NCTX; x++)
        if ((32'(bus.r_layer) == l) && (32'(bus.r_ctx) == x))
          w_rsel = w_rd[l-1][x];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_rdata  <= (bus.r_en && w_rlegal) ? w_rsel : '0;
      r_rvalid <= bus.r_en && w_rlegal;
      r_err    <= (bus.w_en && !w_wlegal) || (bus.r_en && !w_rlegal);
    end
  end

  assign bus.r_data  = r_rdata;
  assign bus.r_valid = r_rvalid;
  assign bus.err     = r_err;
endmodule

// File: tb/tb_scan_beta_store.sv
// Bench for scan_beta_store: two DUTs (read-old and write-first) driven identically,
// compared each cycle against an entry-array model of the store.
module tb_scan_beta_store;
  localparam int Q = 6, P = 128, N = 1024, NCTX = 2, LMAX = 8;
  localparam int LW = 4, CW = 1, XW = 1, PQ = P * Q;

  logic clk = 1'b0;
  logic rst, w_en, r_en, clr;
  logic [LW-1:0]   w_layer, r_layer;
  logic [CW-1:0]   w_cnt, r_cnt;
  logic [XW-1:0]   w_ctx, r_ctx, clr_ctx;
  logic [2*PQ-1:0] w_data;

  int checks = 0;
  int failures = 0;

  logic [Q-1:0] mdl [NCTX][LMAX+1][256];
  logic [Q-1:0] nxt [NCTX][LMAX+1][256];

  always #5 clk = ~clk;

  scan_beta_store_if #(.Q(Q), .P(P), .LW(LW), .CW(CW), .XW(XW)) bus0 ();
  scan_beta_store_if #(.Q(Q), .P(P), .LW(LW), .CW(CW), .XW(XW)) bus1 ();

  assign bus0.w_en = w_en;   assign bus1.w_en = w_en;
  assign bus0.w_layer = w_layer; assign bus1.w_layer = w_layer;
  assign bus0.w_cnt = w_cnt; assign bus1.w_cnt = w_cnt;
  assign bus0.w_ctx = w_ctx; assign bus1.w_ctx = w_ctx;
  assign bus0.w_data = w_data; assign bus1.w_data = w_data;
  assign bus0.r_en = r_en;   assign bus1.r_en = r_en;
  assign bus0.r_layer = r_layer; assign bus1.r_layer = r_layer;
  assign bus0.r_cnt = r_cnt; assign bus1.r_cnt = r_cnt;
  assign bus0.r_ctx = r_ctx; assign bus1.r_ctx = r_ctx;
  assign bus0.clr = clr;     assign bus1.clr = clr;
  assign bus0.clr_ctx = clr_ctx; assign bus1.clr_ctx = clr_ctx;

  scan_beta_store #(.Q(Q), .P(P), .N(N), .NCTX(NCTX), .BYPASS(1'b0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0));
  scan_beta_store #(.Q(Q), .P(P), .N(N), .NCTX(NCTX), .BYPASS(1'b1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1));

  function automatic bit wr_legal(int l, int c, int x);
    int h;
    if (l < 1 || l > LMAX || x >= NCTX) return 1'b0;
    h = (1 << l) / 2;
    if (h >= P) return c < h / P;
    return c == 0;
  endfunction

  function automatic bit rd_legal(int l, int c, int x);
    int s;
    if (l < 1 || l > LMAX || x >= NCTX) return 1'b0;
    s = 1 << l;
    if (s >= P) return c < s / P;
    return c == 0;
  endfunction

  function automatic logic [PQ-1:0] mread(bit from_nxt, int x, int l, int c);
    logic [PQ-1:0] v;
    int s, e;
    v = '0;
    s = 1 << l;
    for (int k = 0; k < P; k++) begin
      e = (s >= P) ? c * P + k : k;
      if (e < s) v[k*Q +: Q] = from_nxt ? nxt[x][l][e] : mdl[x][l][e];
    end
    return v;
  endfunction

  task automatic mwrite(int x, int l, int c);
    int h;
    h = (1 << l) / 2;
    if (h >= P) begin
      for (int k = 0; k < P; k++) begin
        nxt[x][l][c*P + k]     = w_data[k*Q +: Q];
        nxt[x][l][h + c*P + k] = w_data[PQ + k*Q +: Q];
      end
    end else begin
      for (int k = 0; k < h; k++) begin
        nxt[x][l][k]     = w_data[k*Q +: Q];
        nxt[x][l][h + k] = w_data[PQ + k*Q +: Q];
      end
    end
  endtask

  task automatic chk_vec(string tag, logic [PQ-1:0] got, logic [PQ-1:0] exp);
    int bad;
    bad = 0;
    for (int k = P - 1; k >= 0; k--) if (got[k*Q +: Q] !== exp[k*Q +: Q]) bad = k;
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s r_data entry %0d got=%h exp=%h", tag, bad, got[bad*Q +: Q], exp[bad*Q +: Q]);
    end
  endtask

  task automatic chk_bit(string tag, logic got, logic exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic idle();
    rst = 1'b0; w_en = 1'b0; r_en = 1'b0; clr = 1'b0;
  endtask

  // One clock: predict from the model, clock the DUTs, compare, return inputs to idle
  task automatic step(string tag);
    logic [PQ-1:0] e0, e1;
    logic ev, ee;
    bit wl, rl;
    nxt = mdl;
    wl = w_en && wr_legal(int'(w_layer), int'(w_cnt), int'(w_ctx));
    rl = r_en && rd_legal(int'(r_layer), int'(r_cnt), int'(r_ctx));
    if (rst) begin
      e0 = '0; e1 = '0; ev = 1'b0; ee = 1'b0;
      foreach (nxt[x, l, e]) nxt[x][l][e] = '0;
    end else begin
      if (wl && !(clr && clr_ctx == w_ctx)) mwrite(int'(w_ctx), int'(w_layer), int'(w_cnt));
      e0 = rl ? mread(1'b0, int'(r_ctx), int'(r_layer), int'(r_cnt)) : '0;
      e1 = rl ? mread(1'b1, int'(r_ctx), int'(r_layer), int'(r_cnt)) : '0;
      ev = rl;
      ee = (w_en && !wl) || (r_en && !rl);
      if (clr && int'(clr_ctx) < NCTX)
        for (int l = 0; l <= LMAX; l++)
          for (int e = 0; e < 256; e++) nxt[clr_ctx][l][e] = '0;
    end
    @(posedge clk);
    mdl = nxt;
    #1;
    chk_vec({tag, "/data0"}, bus0.r_data, e0);
    chk_vec({tag, "/data1"}, bus1.r_data, e1);
    chk_bit({tag, "/valid0"}, bus0.r_valid, ev);
    chk_bit({tag, "/valid1"}, bus1.r_valid, ev);
    chk_bit({tag, "/err0"}, bus0.err, ee);
    chk_bit({tag, "/err1"}, bus1.err, ee);
    idle();
  endtask

  task automatic rand_data();
    for (int i = 0; i < 2 * PQ / 32; i++) w_data[i*32 +: 32] = $urandom();
  endtask

  task automatic read_all(string tag);
    for (int x = 0; x < NCTX; x++)
      for (int l = 1; l <= LMAX; l++)
        for (int c = 0; c < (((1 << l) >= P) ? (1 << l) / P : 1); c++) begin
          r_en = 1'b1; r_layer = LW'(l); r_ctx = XW'(x); r_cnt = CW'(c);
          step(tag);
        end
  endtask

  initial begin
    foreach (mdl[x, l, e]) mdl[x][l][e] = '0;
    idle();
    w_layer = '0; r_layer = '0; w_cnt = '0; r_cnt = '0;
    w_ctx = '0; r_ctx = '0; clr_ctx = '0; w_data = '0;

    rst = 1'b1; step("reset");

    // Layer 8 ctx 0: one write fills both halves
    for (int k = 0; k < P; k++) begin
      w_data[k*Q +: Q]      = Q'(k % 64);
      w_data[PQ + k*Q +: Q] = Q'((k + 17) % 64);
    end
    w_en = 1'b1; w_layer = 4'd8; w_cnt = 1'b0; w_ctx = 1'b0; step("l8_wr");
    r_en = 1'b1; r_layer = 4'd8; r_cnt = 1'b0; r_ctx = 1'b0; step("l8_rd0");
    chk_vec("l8_rd0_const", bus0.r_data, mread(1'b0, 0, 8, 0));
    r_en = 1'b1; r_layer = 4'd8; r_cnt = 1'b1; r_ctx = 1'b0; step("l8_rd1");
    chk_bit("l8_rd1_entry3", bus0.r_data[3*Q +: Q] == 6'd20, 1'b1);

    // Layer 3 ctx 1: small layer, zero-extended read
    w_data = '0;
    for (int k = 0; k < 4; k++) begin
      w_data[k*Q +: Q]      = Q'(k + 1);
      w_data[PQ + k*Q +: Q] = Q'(k + 5);
    end
    w_en = 1'b1; w_layer = 4'd3; w_cnt = 1'b0; w_ctx = 1'b1; step("l3_wr");
    r_en = 1'b1; r_layer = 4'd3; r_cnt = 1'b0; r_ctx = 1'b1; step("l3_rd_c1");
    chk_bit("l3_entry7", bus0.r_data[7*Q +: Q] == 6'd8, 1'b1);
    r_en = 1'b1; r_layer = 4'd3; r_cnt = 1'b0; r_ctx = 1'b0; step("l3_rd_c0");

    // Illegal accesses
    rand_data();
    w_en = 1'b1; w_layer = 4'd8; w_cnt = 1'b1; w_ctx = 1'b0; step("ill_wr_cnt");
    step("ill_err_drop");
    r_en = 1'b1; r_layer = 4'd8; r_cnt = 1'b0; r_ctx = 1'b0; step("l8_unchanged");
    r_en = 1'b1; r_layer = 4'd9; r_cnt = 1'b0; r_ctx = 1'b0; step("ill_rd_l9");
    w_en = 1'b1; w_layer = 4'd0; w_cnt = 1'b0; step("ill_wr_l0");

    // Same-cycle collision on layer 5
    for (int k = 0; k < 2 * P; k++) w_data[k*Q +: Q] = 6'h2A;
    w_en = 1'b1; w_layer = 4'd5; w_cnt = 1'b0; w_ctx = 1'b0;
    r_en = 1'b1; r_layer = 4'd5; r_cnt = 1'b0; r_ctx = 1'b0; step("collide_l5");
    chk_bit("collide_byp_e31", bus1.r_data[31*Q +: Q] == 6'h2A, 1'b1);

    // Randomised traffic with frequent collisions and occasional clears
    for (int i = 0; i < 300; i++) begin
      rand_data();
      w_en = 1'($urandom_range(0, 1)); w_layer = LW'($urandom_range(0, 9));
      w_cnt = CW'($urandom_range(0, 1)); w_ctx = XW'($urandom_range(0, 1));
      r_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) begin
        r_layer = w_layer; r_ctx = w_ctx; r_cnt = CW'($urandom_range(0, 1));
      end else begin
        r_layer = LW'($urandom_range(0, 9)); r_ctx = XW'($urandom_range(0, 1));
        r_cnt = CW'($urandom_range(0, 1));
      end
      clr = ($urandom_range(0, 15) == 0); clr_ctx = XW'($urandom_range(0, 1));
      step("rand");
    end

    // Fill both contexts, then clear ctx 0 alongside a write and read to it
    for (int x = 0; x < NCTX; x++)
      for (int l = 1; l <= LMAX; l++) begin
        rand_data();
        w_en = 1'b1; w_layer = LW'(l); w_cnt = 1'b0; w_ctx = XW'(x); step("fill");
      end
    rand_data();
    clr = 1'b1; clr_ctx = 1'b0;
    w_en = 1'b1; w_layer = 4'd4; w_cnt = 1'b0; w_ctx = 1'b0;
    r_en = 1'b1; r_layer = 4'd4; r_cnt = 1'b0; r_ctx = 1'b0; step("clr_collide");
    read_all("after_clr");

    // Reset in the middle of traffic
    rand_data();
    rst = 1'b1; w_en = 1'b1; w_layer = 4'd6; w_cnt = 1'b0; w_ctx = 1'b1;
    r_en = 1'b1; r_layer = 4'd6; r_cnt = 1'b0; r_ctx = 1'b1; step("mid_reset");
    read_all("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
